// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM burst-to-stream reader: sizing helpers,
// read-latency decode and FSM state encoding.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bits needed to hold the value n (at least 1).
  function automatic int clogb2(input int n);
    int v;
    int r;
    v = n;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int lat_of(input string perf);
    return (perf == "LOW_LATENCY") ? 1 : 2;
  endfunction

endpackage

// File: rtl/bram_stream_reader_sync_fifo.sv
// Small first-word-fall-through FIFO holding {last, data} beats for the
// stream side; read data reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive words from a BRAM port and presents them as a
// ready/valid stream, throttling reads so the output buffer can never overflow.
//
// state    | meaning
// ST_IDLE  | waiting for start (ignored during the done pulse)
// ST_ISSUE | issuing reads as buffer credit allows
// ST_DRAIN | all reads issued, waiting for the tlast handshake
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter int    FIFO_DEPTH      = 4,
  localparam int   AW              = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW-1:0]        len_m1,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        ram_addr,
  output logic                 ram_en,
  output logic                 ram_regce,
  input  logic [RAM_WIDTH-1:0] ram_dout,
  output logic [RAM_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
);

  localparam int LAT = lat_of(RAM_PERFORMANCE);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic [AW-1:0]   rem;
  logic [LAT-1:0]  vld;
  logic [LAT-1:0]  lst;
  int              inflight;
  logic            credit_ok;
  logic            last_hs;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [RAM_WIDTH:0] fifo_rd;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < LAT; i++) inflight += int'(vld[i]);
  end

  // Reads in the RAM pipeline already own a buffer slot.
  assign credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;
  assign last_hs   = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ram_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !done) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          ram_en = 1'b1;
          if (rem == '0) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_hs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
      rem      <= '0;
      done     <= 1'b0;
    end else begin
      done <= last_hs && (state == ST_DRAIN);
      if (accept) begin
        ram_addr <= base_addr;
        rem      <= len_m1;
      end else if (ram_en) begin
        ram_addr <= (ram_addr == AW'(RAM_DEPTH - 1)) ? '0 : ram_addr + 1'b1;
        rem      <= rem - 1'b1;
      end
    end
  end

  // Clearing these tags on reset is what discards read data still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
      vld[0] <= ram_en;
      lst[0] <= ram_en && (rem == '0);
    end
  end

  assign ram_regce = (LAT == 2) ? vld[0] : 1'b0;

  sync_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld[LAT-1]),
    .wr_data ({lst[LAT-1], ram_dout}),
    .rd_en   (m_axis_tready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tlast  = fifo_rd[RAM_WIDTH];
  assign m_axis_tdata  = fifo_rd[RAM_WIDTH-1:0];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: LAT=2 and LAT=1 instances, each
// driving a behavioural RAM preloaded with mem[i]=i.
module tb_bram_stream_reader;
  localparam int W  = 18;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  // LAT=2 instance (suffix _a) and LAT=1 instance (suffix _b)
  logic          rst_a, start_a, busy_a, done_a, ram_en_a, ram_regce_a;
  logic [AW-1:0] base_a, len_a, ram_addr_a;
  logic [W-1:0]  ram_dout_a, tdata_a;
  logic          tvalid_a, tready_a, tlast_a;

  logic          rst_b, start_b, busy_b, done_b, ram_en_b, ram_regce_b;
  logic [AW-1:0] base_b, len_b, ram_addr_b;
  logic [W-1:0]  ram_dout_b, tdata_b;
  logic          tvalid_b, tready_b, tlast_b;

  bram_stream_reader #(
    .RAM_WIDTH(W), .RAM_DEPTH(1024), .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .base_addr(base_a), .len_m1(len_a),
    .busy(busy_a), .done(done_a), .ram_addr(ram_addr_a), .ram_en(ram_en_a),
    .ram_regce(ram_regce_a), .ram_dout(ram_dout_a), .m_axis_tdata(tdata_a),
    .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a), .m_axis_tlast(tlast_a)
  );

  bram_stream_reader #(
    .RAM_WIDTH(W), .RAM_DEPTH(1024), .RAM_PERFORMANCE("LOW_LATENCY"), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .base_addr(base_b), .len_m1(len_b),
    .busy(busy_b), .done(done_b), .ram_addr(ram_addr_b), .ram_en(ram_en_b),
    .ram_regce(ram_regce_b), .ram_dout(ram_dout_b), .m_axis_tdata(tdata_b),
    .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b), .m_axis_tlast(tlast_b)
  );

  // RAM models: latch on en, optional output register on regce
  logic [W-1:0] mem [1024];
  logic [W-1:0] r1_a, r2_a, r1_b;
  initial for (int i = 0; i < 1024; i++) mem[i] = W'(i);

  always @(posedge clk) begin
    if (ram_en_a)    r1_a <= mem[ram_addr_a];
    if (ram_regce_a) r2_a <= r1_a;
    if (ram_en_b)    r1_b <= mem[ram_addr_b];
  end
  assign ram_dout_a = r2_a;
  assign ram_dout_b = r1_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboards of {last, data}
  logic [W:0] q_a[$];
  logic [W:0] q_b[$];

  logic       pv_a = 1'b0, pr_a = 1'b0;
  logic [W:0] pd_a = '0;

  always @(negedge clk) begin
    if (tvalid_a && tready_a) begin
      if (q_a.size() == 0) chk("a_unexpected_beat", {13'd0, tlast_a, tdata_a}, 32'hFFFF_FFFF);
      else chk("a_beat", {13'd0, tlast_a, tdata_a}, {13'd0, q_a.pop_front()});
    end
    if (pv_a && !pr_a && !rst_a)
      chk("a_hold", {12'd0, tvalid_a, tlast_a, tdata_a}, {12'd0, 1'b1, pd_a});
    pv_a <= tvalid_a;
    pr_a <= tready_a;
    pd_a <= {tlast_a, tdata_a};
  end

  always @(negedge clk) begin
    if (tvalid_b && tready_b) begin
      if (q_b.size() == 0) chk("b_unexpected_beat", {13'd0, tlast_b, tdata_b}, 32'hFFFF_FFFF);
      else chk("b_beat", {13'd0, tlast_b, tdata_b}, {13'd0, q_b.pop_front()});
    end
  end

  // Outstanding reads = in-flight + buffered, reconstructed from the ports
  int iss_a = 0, acc_a = 0, max_out = 0;
  always @(posedge clk) begin
    if (rst_a) begin
      iss_a <= 0;
      acc_a <= 0;
    end else begin
      iss_a <= iss_a + int'(ram_en_a);
      acc_a <= acc_a + int'(tvalid_a && tready_a);
    end
  end
  always @(negedge clk) if (iss_a - acc_a > max_out) max_out <= iss_a - acc_a;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 tvalid_a, 1 done_a, 2 tvalid_b, 3 done_b; c = cycle seen or -1
  task automatic run_until(input int which, input int budget, input bit rnd, output int c);
    logic s;
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (which)
        0: s = tvalid_a;
        1: s = done_a;
        2: s = tvalid_b;
        default: s = done_b;
      endcase
      if (s) begin
        c = cyc;
        break;
      end
      if (rnd) tready_a = ($urandom_range(0, 99) < 30);
    end
    if (c < 0) $display("FAIL wait_%0d: no event within %0d cycles", which, budget);
  endtask

  task automatic push_a(input int base, input int n);
    for (int i = 0; i < n; i++) q_a.push_back({(i == n - 1), W'((base + i) % 1024)});
  endtask

  task automatic zeros_a(input string tag);
    chk({tag, "_busy"},   busy_a,      0);
    chk({tag, "_done"},   done_a,      0);
    chk({tag, "_ram_en"}, ram_en_a,    0);
    chk({tag, "_regce"},  ram_regce_a, 0);
    chk({tag, "_addr"},   ram_addr_a,  0);
    chk({tag, "_tvalid"}, tvalid_a,    0);
    chk({tag, "_tlast"},  tlast_a,     0);
    chk({tag, "_tdata"},  tdata_a,     0);
  endtask

  task automatic start_burst_a(input logic [AW-1:0] base, input logic [AW-1:0] len, output int t0);
    step();
    start_a = 1'b1;
    base_a  = base;
    len_a   = len;
    t0      = cyc;
    step();
    start_a = 1'b0;
  endtask

  initial begin
    int t0, c, ndone;
    rst_a = 1'b1; start_a = 1'b0; base_a = '0; len_a = '0; tready_a = 1'b1;
    rst_b = 1'b1; start_b = 1'b0; base_b = '0; len_b = '0; tready_b = 1'b1;
    repeat (3) step();
    @(negedge clk);
    zeros_a("rst_a");
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_tvalid", tvalid_b, 0);
    chk("rst_b_regce", ram_regce_b, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // base 0x010, 8 beats, tready high
    push_a(16, 8);
    start_burst_a(10'h010, 10'd7, t0);
    @(negedge clk);
    chk("a_c1_busy", busy_a, 1);
    chk("a_c1_ram_en", ram_en_a, 1);
    chk("a_c1_addr", ram_addr_a, 32'h010);
    run_until(0, 20, 0, c);
    chk("a_first_valid_cycle", c - t0, 4);
    run_until(1, 30, 0, c);
    chk("a_done_cycle", c - t0, 12);
    chk("a_q_empty_1", q_a.size(), 0);

    // wrap 0x3FE..0x001, then start during the done pulse is ignored
    push_a(10'h3FE, 4);
    start_burst_a(10'h3FE, 10'd3, t0);
    run_until(1, 30, 0, c);
    chk("a_wrap_done_cycle", c - t0, 8);
    start_a = 1'b1;
    base_a  = 10'h123;
    len_a   = 10'd2;
    step();
    start_a = 1'b0;
    @(negedge clk);
    chk("a_done_cycle_start_ignored", busy_a, 0);
    chk("a_q_empty_2", q_a.size(), 0);

    // 16 beats under random backpressure, plus a start while busy
    tready_a = 1'b0;
    push_a(10'h040, 16);
    start_burst_a(10'h040, 10'd15, t0);
    step();
    start_a = 1'b1;
    base_a  = 10'h200;
    len_a   = 10'd3;
    step();
    start_a = 1'b0;
    run_until(1, 600, 1, c);
    chk("a_rand_done_seen", (c >= 0), 1);
    tready_a = 1'b1;
    compared++;
    if (max_out > 4) begin
      mismatched++;
      $display("FAIL a_outstanding: got %0d required at most 4", max_out);
    end
    step();
    step();
    chk("a_q_empty_3", q_a.size(), 0);
    chk("a_idle_after_rand", busy_a, 0);

    // reset in cycle 5 of a 32-word burst, then a clean burst at 0x100
    push_a(10'h020, 32);
    start_burst_a(10'h020, 10'd31, t0);
    repeat (4) step();
    rst_a = 1'b1;
    step();
    @(negedge clk);
    zeros_a("mid_rst");
    rst_a = 1'b0;
    q_a.delete();
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ndone += int'(done_a);
    end
    chk("a_no_done_after_rst", ndone, 0);
    push_a(10'h100, 8);
    start_burst_a(10'h100, 10'd7, t0);
    run_until(1, 30, 0, c);
    chk("a_post_rst_done_cycle", c - t0, 12);
    chk("a_q_empty_4", q_a.size(), 0);

    // LAT=1: single beat, second start while busy ignored
    q_b.push_back({1'b1, W'(0)});
    step();
    start_b = 1'b1;
    base_b  = '0;
    len_b   = '0;
    t0      = cyc;
    step();
    start_b = 1'b0;
    step();
    start_b = 1'b1;
    base_b  = 10'd5;
    len_b   = 10'd3;
    step();
    start_b = 1'b0;
    run_until(2, 10, 0, c);
    chk("b_valid_cycle", c - t0, 3);
    chk("b_tlast", tlast_b, 1);
    run_until(3, 10, 0, c);
    chk("b_done_cycle", c - t0, 4);
    repeat (6) step();
    @(negedge clk);
    chk("b_idle_after", busy_b, 0);
    chk("b_q_empty", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
